alu_dest_wb: RTL and testbench
==============================

Name: alu_dest_wb

Overview:
- Write-back/destination stage of the PIC10F200 datapath, feeding the opposite direction from the ALU input selection.
- Takes the ALU result and routes it by the instruction's d bit: d=0 to the W register held in this block, d=1 to the RAM/file write port through a ready handshake.
- Owns the STATUS Z, DC and C flags and applies the PIC STATUS-destination precedence rule.
- Sits between the ALU output and the RAM write port; the control unit sequences it.

Parameters:
- STATUS_ADDR, 5'h03, file address of the STATUS register.
- WR_TIMEOUT, 15, maximum number of RAM_WR cycles to wait for ram_ready before aborting (range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wb_req  input  1  one-cycle request; operands below are valid in the same cycle.
- alu_out  input  8  ALU result.
- alu_c  input  1  ALU carry/borrow out.
- alu_dc  input  1  ALU digit carry out.
- dest_sel  input  1  d bit: 1 = RAM/file, 0 = W.
- file_addr  input  5  destination file address.
- upd_z  input  1  instruction affects Z.
- upd_c  input  1  instruction affects C.
- upd_dc  input  1  instruction affects DC.
- ram_ready  input  1  RAM accepts the write this cycle.
- w_reg  output  8  W register.
- ram_we  output  1  RAM write strobe.
- ram_waddr  output  5  RAM write address.
- ram_wdata  output  8  RAM write data.
- status_z  output  1  Z flag.
- status_dc  output  1  DC flag.
- status_c  output  1  C flag.
- wb_busy  output  1  block not in IDLE.
- wb_done  output  1  one-cycle completion pulse.
- wb_err  output  1  one-cycle pulse with wb_done on RAM timeout.
- wb_drop  output  1  one-cycle pulse when wb_req is ignored.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE and the timeout counter clears.
  - w_reg=8'h00, ram_waddr=5'h00, ram_wdata=8'h00.
  - ram_we, status_z, status_dc, status_c, wb_busy, wb_done, wb_err and wb_drop all go to 0.
  - Reset mid-operation abandons the transfer; no partial write is completed.
- All outputs are registered. wb_busy=1 in every state except IDLE.
- State machine: IDLE, EXEC, RAM_WR, DONE.
- IDLE: on wb_req=1, capture all operands into internal registers and go to EXEC.
- EXEC (one cycle), evaluated on the edge leaving EXEC:
  - Flags update: Z <= (alu_out==0) if upd_z; C <= alu_c if upd_c; DC <= alu_dc if upd_dc. Each flag holds its value when its enable is 0.
  - dest_sel=0: w_reg <= alu_out, then go to DONE.
  - dest_sel=1: load ram_waddr and ram_wdata, set ram_we=1, clear the timeout counter, then go to RAM_WR.
- STATUS destination (dest_sel=1 and file_addr==STATUS_ADDR):
  - Each flag with its upd_* = 1 takes the ALU-derived value.
  - Each flag with its upd_* = 0 loads from the data: Z=alu_out[2], DC=alu_out[1], C=alu_out[0].
  - ram_wdata = alu_out with bits [2:0] replaced by the final {Z,DC,C}.
- RAM_WR: ram_we, ram_waddr and ram_wdata are held stable.
  - ram_ready=1 at an edge: ram_we <= 0, go to DONE.
  - Otherwise the counter increments. When the counter reaches WR_TIMEOUT without ram_ready: ram_we <= 0, go to DONE, and wb_err=1 during DONE.
- DONE: wb_done=1 for exactly this cycle.
  - wb_req=1 in DONE is accepted: capture operands and go to EXEC (back-to-back operation).
  - Otherwise go to IDLE.
- Latency, with wb_req sampled at edge k:
  - W destination: wb_done high in cycle k+2.
  - RAM destination with ram_ready already high: ram_we high in cycle k+2, wb_done high in cycle k+3.
  - Each wait cycle on ram_ready adds one cycle.
- wb_req while in EXEC or RAM_WR: ignored, wb_drop=1 for the following cycle, and the current operation is unaffected.
- w_reg changes only from the EXEC edge with dest_sel=0. A RAM-destination operation never modifies w_reg.

Test Plan:
- W path: reset, then wb_req with alu_out=8'h00, dest_sel=0, upd_z=1 -> w_reg=8'h00, status_z=1, wb_done high 2 cycles after the request, ram_we never asserted.
- RAM path: alu_out=8'hA5, file_addr=5'h10, dest_sel=1, ram_ready tied 1 -> ram_we high for exactly 1 cycle with addr 5'h10 and data 8'hA5, w_reg unchanged, wb_done the next cycle.
- STATUS precedence: alu_out=8'hFF to STATUS_ADDR with upd_z=1 (result nonzero) and upd_c=upd_dc=0 -> Z=0, C=1, DC=1, ram_wdata=8'hFB.
- Timeout: dest_sel=1, ram_ready held 0 -> ram_we high for 15 cycles, then ram_we=0 with wb_done=1 and wb_err=1 in the same cycle, flags already updated.
- Overlap and back-to-back: wb_req during RAM_WR -> wb_drop pulse and the first write completes unchanged; wb_req during DONE -> accepted with no IDLE cycle in between.
- Reset mid-RAM_WR: assert rst_n=0 while ram_we=1 -> all outputs 0 immediately (asynchronously); after release the block is IDLE and the next request behaves normally.

Source files
------------

// File: rtl/alu_dest_wb.sv
// Purpose : PIC10F200 write-back stage; routes the ALU result to W or to a RAM write, owns STATUS Z/DC/C.
// Latency : wb_req at edge k -> wb_done in k+2 (W), ram_we in k+2 and wb_done in k+3 (RAM, ready high).
// Backpr. : RAM write waits on ram_ready up to WR_TIMEOUT cycles; requests during EXEC/RAM_WR are dropped.
//
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   wb_req                          one-cycle request; alu_out/alu_c/alu_dc/dest_sel/file_addr/upd_* valid with it
//   ram_ready                       RAM accepts the pending write this cycle
//   w_reg                           W register
//   ram_we, ram_waddr, ram_wdata    RAM write port, held stable while waiting
//   status_z, status_dc, status_c   STATUS flags
//   wb_busy, wb_done, wb_err        not-idle level, completion pulse, timeout pulse (with wb_done)
//   wb_drop                         pulse one cycle after a request that arrived while busy
module alu_dest_wb #(
   parameter logic [4:0]  STATUS_ADDR = 5'h03,
   parameter int unsigned WR_TIMEOUT  = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wb_req,
   input  logic [7:0] alu_out,
   input  logic       alu_c,
   input  logic       alu_dc,
   input  logic       dest_sel,
   input  logic [4:0] file_addr,
   input  logic       upd_z,
   input  logic       upd_c,
   input  logic       upd_dc,
   input  logic       ram_ready,
   output logic [7:0] w_reg,
   output logic       ram_we,
   output logic [4:0] ram_waddr,
   output logic [7:0] ram_wdata,
   output logic       status_z,
   output logic       status_dc,
   output logic       status_c,
   output logic       wb_busy,
   output logic       wb_done,
   output logic       wb_err,
   output logic       wb_drop
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXEC   = 2'd1,
      RAM_WR = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(WR_TIMEOUT);

   state_t     r_state;
   state_t     w_state_nxt;

   // Operands captured on acceptance; EXEC works only from these copies.
   logic [7:0] r_alu;
   logic       r_c;
   logic       r_dc;
   logic       r_dest;
   logic [4:0] r_addr;
   logic       r_upd_z;
   logic       r_upd_c;
   logic       r_upd_dc;
   logic [7:0] r_cnt;

   logic       w_accept;
   logic       w_drop_nxt;
   logic       w_timeout;
   logic [7:0] w_cnt_inc;
   logic       w_status_dst;
   logic       w_z_fin;
   logic       w_dc_fin;
   logic       w_c_fin;
   logic [7:0] w_wdata;

   assign w_cnt_inc = r_cnt + 8'd1;

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_drop_nxt  = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            if (wb_req) begin
               w_accept    = 1'b1;
               w_state_nxt = EXEC;
            end
         end
         EXEC: begin
            w_state_nxt = r_dest ? RAM_WR : DONE;
            w_drop_nxt  = wb_req;
         end
         RAM_WR: begin
            w_drop_nxt = wb_req;
            if (ram_ready) begin
               w_state_nxt = DONE;
            end else if (w_cnt_inc == TIMEOUT_CNT) begin
               w_state_nxt = DONE;
               w_timeout   = 1'b1;
            end
         end
         DONE: begin
            if (wb_req) begin
               w_accept    = 1'b1;
               w_state_nxt = EXEC;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Flag resolution. A write to STATUS itself lets the data bits supply any
   // flag the instruction does not update; updated flags still win.
   always_comb begin
      w_status_dst = r_dest && (r_addr == STATUS_ADDR);
      w_z_fin      = r_upd_z  ? (r_alu == 8'h00) : (w_status_dst ? r_alu[2] : status_z);
      w_dc_fin     = r_upd_dc ? r_dc             : (w_status_dst ? r_alu[1] : status_dc);
      w_c_fin      = r_upd_c  ? r_c              : (w_status_dst ? r_alu[0] : status_c);
      w_wdata      = w_status_dst ? {r_alu[7:3], w_z_fin, w_dc_fin, w_c_fin} : r_alu;
   end

   // Operand capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu    <= 8'h00;
         r_c      <= 1'b0;
         r_dc     <= 1'b0;
         r_dest   <= 1'b0;
         r_addr   <= 5'h00;
         r_upd_z  <= 1'b0;
         r_upd_c  <= 1'b0;
         r_upd_dc <= 1'b0;
      end else if (w_accept) begin
         r_alu    <= alu_out;
         r_c      <= alu_c;
         r_dc     <= alu_dc;
         r_dest   <= dest_sel;
         r_addr   <= file_addr;
         r_upd_z  <= upd_z;
         r_upd_c  <= upd_c;
         r_upd_dc <= upd_dc;
      end
   end

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= 8'h00;
         w_reg     <= 8'h00;
         ram_we    <= 1'b0;
         ram_waddr <= 5'h00;
         ram_wdata <= 8'h00;
         status_z  <= 1'b0;
         status_dc <= 1'b0;
         status_c  <= 1'b0;
         wb_busy   <= 1'b0;
         wb_done   <= 1'b0;
         wb_err    <= 1'b0;
         wb_drop   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         wb_busy <= (w_state_nxt != IDLE);
         wb_done <= (w_state_nxt == DONE);
         wb_err  <= w_timeout;
         wb_drop <= w_drop_nxt;
         case (r_state)
            EXEC: begin
               status_z  <= w_z_fin;
               status_dc <= w_dc_fin;
               status_c  <= w_c_fin;
               if (!r_dest) begin
                  w_reg <= r_alu;
               end else begin
                  ram_we    <= 1'b1;
                  ram_waddr <= r_addr;
                  ram_wdata <= w_wdata;
                  r_cnt     <= 8'h00;
               end
            end
            RAM_WR: begin
               if (w_state_nxt == DONE) begin
                  ram_we <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_dest_wb.sv
// Purpose : directed self-checking bench for alu_dest_wb.
// Latency : inputs driven and outputs sampled 1 ns after each rising edge.
// Backpr. : ram_ready driven per scenario; every wait is cycle-bounded.
module tb_alu_dest_wb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wb_req;
   logic [7:0] alu_out;
   logic       alu_c;
   logic       alu_dc;
   logic       dest_sel;
   logic [4:0] file_addr;
   logic       upd_z;
   logic       upd_c;
   logic       upd_dc;
   logic       ram_ready;
   logic [7:0] w_reg;
   logic       ram_we;
   logic [4:0] ram_waddr;
   logic [7:0] ram_wdata;
   logic       status_z;
   logic       status_dc;
   logic       status_c;
   logic       wb_busy;
   logic       wb_done;
   logic       wb_err;
   logic       wb_drop;

   int n_checks = 0;
   int n_errors = 0;

   alu_dest_wb dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb_req    (wb_req),
      .alu_out   (alu_out),
      .alu_c     (alu_c),
      .alu_dc    (alu_dc),
      .dest_sel  (dest_sel),
      .file_addr (file_addr),
      .upd_z     (upd_z),
      .upd_c     (upd_c),
      .upd_dc    (upd_dc),
      .ram_ready (ram_ready),
      .w_reg     (w_reg),
      .ram_we    (ram_we),
      .ram_waddr (ram_waddr),
      .ram_wdata (ram_wdata),
      .status_z  (status_z),
      .status_dc (status_dc),
      .status_c  (status_c),
      .wb_busy   (wb_busy),
      .wb_done   (wb_done),
      .wb_err    (wb_err),
      .wb_drop   (wb_drop)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [7:0] a, input logic d, input logic [4:0] fa,
                         input logic uz, input logic uc, input logic udc,
                         input logic ac, input logic adc);
      alu_out   = a;
      dest_sel  = d;
      file_addr = fa;
      upd_z     = uz;
      upd_c     = uc;
      upd_dc    = udc;
      alu_c     = ac;
      alu_dc    = adc;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      wb_req = 1'b0;
      ram_ready = 1'b0;
      set_op(8'h00, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #12;
      n_checks++; if (w_reg !== 8'h00) begin n_errors++; $display("FAIL rst_w_reg: got %h want 00", w_reg); end
      n_checks++; if (ram_waddr !== 5'h00) begin n_errors++; $display("FAIL rst_waddr: got %h want 00", ram_waddr); end
      n_checks++; if (ram_wdata !== 8'h00) begin n_errors++; $display("FAIL rst_wdata: got %h want 00", ram_wdata); end
      n_checks++;
      if ({ram_we, status_z, status_dc, status_c, wb_busy, wb_done, wb_err, wb_drop} !== 8'h00) begin
         n_errors++;
         $display("FAIL rst_bits: got %b want 00000000",
                  {ram_we, status_z, status_dc, status_c, wb_busy, wb_done, wb_err, wb_drop});
      end
      @(negedge clk) rst_n = 1'b1;
      tick;
      n_checks++; if (wb_busy !== 1'b0) begin n_errors++; $display("FAIL rst_idle_busy: got %b want 0", wb_busy); end
   endtask

   task automatic test_w_path;
      logic saw_we;
      saw_we = 1'b0;
      set_op(8'h00, 1'b0, 5'h1F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      wb_req = 1'b1;
      tick;
      wb_req = 1'b0;
      saw_we |= ram_we;
      n_checks++; if ({wb_busy, wb_done} !== 2'b10) begin n_errors++; $display("FAIL w_exec_busy_done: got %b want 10", {wb_busy, wb_done}); end
      tick;
      saw_we |= ram_we;
      n_checks++; if (wb_done !== 1'b1) begin n_errors++; $display("FAIL w_done_k2: got %b want 1", wb_done); end
      n_checks++; if (w_reg !== 8'h00) begin n_errors++; $display("FAIL w_reg_zero: got %h want 00", w_reg); end
      n_checks++; if ({status_z, status_dc, status_c} !== 3'b100) begin n_errors++; $display("FAIL w_flags_zero: got %b want 100", {status_z, status_dc, status_c}); end
      tick;
      saw_we |= ram_we;
      n_checks++; if ({wb_busy, wb_done, saw_we} !== 3'b000) begin n_errors++; $display("FAIL w_idle_nowe: got %b want 000", {wb_busy, wb_done, saw_we}); end
      // All three flags updated from a nonzero result
      set_op(8'h3C, 1'b0, 5'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      wb_req = 1'b1;
      tick;
      wb_req = 1'b0;
      tick;
      n_checks++; if ({wb_done, w_reg} !== {1'b1, 8'h3C}) begin n_errors++; $display("FAIL w2_done_reg: got %b/%h want 1/3c", wb_done, w_reg); end
      n_checks++; if ({status_z, status_dc, status_c} !== 3'b001) begin n_errors++; $display("FAIL w2_flags: got %b want 001", {status_z, status_dc, status_c}); end
      tick;
   endtask

   task automatic test_ram_path;
      ram_ready = 1'b1;
      set_op(8'hA5, 1'b1, 5'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      wb_req = 1'b1;
      tick;
      wb_req = 1'b0;
      n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL ram_we_exec: got %b want 0", ram_we); end
      tick;
      n_checks++; if ({ram_we, wb_done} !== 2'b10) begin n_errors++; $display("FAIL ram_we_k2: got %b want 10", {ram_we, wb_done}); end
      n_checks++; if ({ram_waddr, ram_wdata} !== {5'h10, 8'hA5}) begin n_errors++; $display("FAIL ram_addr_data: got %h/%h want 10/a5", ram_waddr, ram_wdata); end
      tick;
      n_checks++; if ({ram_we, wb_done, wb_err} !== 3'b010) begin n_errors++; $display("FAIL ram_done_k3: got %b want 010", {ram_we, wb_done, wb_err}); end
      n_checks++; if (w_reg !== 8'h3C) begin n_errors++; $display("FAIL ram_w_keep: got %h want 3c", w_reg); end
      n_checks++; if ({status_z, status_dc, status_c} !== 3'b001) begin n_errors++; $display("FAIL ram_flags_keep: got %b want 001", {status_z, status_dc, status_c}); end
      tick;
   endtask

   task automatic test_status;
      ram_ready = 1'b1;
      set_op(8'hFF, 1'b1, 5'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      wb_req = 1'b1;
      tick;
      wb_req = 1'b0;
      tick;
      n_checks++; if ({ram_we, ram_waddr, ram_wdata} !== {1'b1, 5'h03, 8'hFB}) begin n_errors++; $display("FAIL stat_write: got %b/%h/%h want 1/03/fb", ram_we, ram_waddr, ram_wdata); end
      n_checks++; if ({status_z, status_dc, status_c} !== 3'b011) begin n_errors++; $display("FAIL stat_flags: got %b want 011", {status_z, status_dc, status_c}); end
      tick;
      n_checks++; if (wb_done !== 1'b1) begin n_errors++; $display("FAIL stat_done: got %b want 1", wb_done); end
      tick;
   endtask

   task automatic test_timeout;
      int  n;
      logic stable;
      n = 0;
      stable = 1'b1;
      ram_ready = 1'b0;
      set_op(8'h00, 1'b1, 5'h05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      wb_req = 1'b1;
      tick;
      wb_req = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (ram_we) begin
            n++;
            if (ram_waddr !== 5'h05 || ram_wdata !== 8'h00 || wb_done !== 1'b0) stable = 1'b0;
         end else begin
            break;
         end
      end
      n_checks++; if (n !== 15) begin n_errors++; $display("FAIL to_we_cycles: got %0d want 15", n); end
      n_checks++; if (stable !== 1'b1) begin n_errors++; $display("FAIL to_hold: got %b want 1", stable); end
      n_checks++; if ({ram_we, wb_done, wb_err} !== 3'b011) begin n_errors++; $display("FAIL to_done_err: got %b want 011", {ram_we, wb_done, wb_err}); end
      n_checks++; if ({status_z, status_dc, status_c} !== 3'b110) begin n_errors++; $display("FAIL to_flags: got %b want 110", {status_z, status_dc, status_c}); end
      tick;
      n_checks++; if ({wb_busy, wb_done, wb_err} !== 3'b000) begin n_errors++; $display("FAIL to_idle: got %b want 000", {wb_busy, wb_done, wb_err}); end
   endtask

   task automatic test_back_to_back;
      ram_ready = 1'b0;
      set_op(8'h5A, 1'b1, 5'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wb_req = 1'b1;
      tick;
      wb_req = 1'b0;
      tick;
      // Request arriving during RAM_WR must be dropped
      set_op(8'h77, 1'b0, 5'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      wb_req = 1'b1;
      tick;
      wb_req = 1'b0;
      ram_ready = 1'b1;
      n_checks++; if ({wb_drop, ram_we} !== 2'b11) begin n_errors++; $display("FAIL b2b_drop: got %b want 11", {wb_drop, ram_we}); end
      n_checks++; if ({ram_waddr, ram_wdata} !== {5'h11, 8'h5A}) begin n_errors++; $display("FAIL b2b_hold: got %h/%h want 11/5a", ram_waddr, ram_wdata); end
      tick;
      n_checks++; if ({wb_done, wb_drop, ram_we, wb_err} !== 4'b1000) begin n_errors++; $display("FAIL b2b_first_done: got %b want 1000", {wb_done, wb_drop, ram_we, wb_err}); end
      n_checks++; if ({w_reg, status_z, status_dc, status_c} !== {8'h3C, 3'b110}) begin n_errors++; $display("FAIL b2b_unaffected: got %h/%b want 3c/110", w_reg, {status_z, status_dc, status_c}); end
      // Request in DONE is taken straight into EXEC
      set_op(8'h77, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wb_req = 1'b1;
      tick;
      wb_req = 1'b0;
      n_checks++; if ({wb_busy, wb_done, wb_drop} !== 3'b100) begin n_errors++; $display("FAIL b2b_exec: got %b want 100", {wb_busy, wb_done, wb_drop}); end
      tick;
      n_checks++; if ({wb_done, w_reg} !== {1'b1, 8'h77}) begin n_errors++; $display("FAIL b2b_second: got %b/%h want 1/77", wb_done, w_reg); end
      tick;
   endtask

   task automatic test_reset_mid;
      ram_ready = 1'b0;
      set_op(8'h99, 1'b1, 5'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      wb_req = 1'b1;
      tick;
      wb_req = 1'b0;
      tick;
      n_checks++; if (ram_we !== 1'b1) begin n_errors++; $display("FAIL mid_we_before: got %b want 1", ram_we); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({w_reg, ram_waddr, ram_wdata, ram_we, status_z, status_dc, status_c,
           wb_busy, wb_done, wb_err, wb_drop} !== 29'h0) begin
         n_errors++;
         $display("FAIL mid_async_clear: got w=%h a=%h d=%h bits=%b want all 0", w_reg, ram_waddr, ram_wdata,
                  {ram_we, status_z, status_dc, status_c, wb_busy, wb_done, wb_err, wb_drop});
      end
      @(negedge clk) rst_n = 1'b1;
      tick;
      n_checks++; if ({wb_busy, ram_we} !== 2'b00) begin n_errors++; $display("FAIL mid_idle: got %b want 00", {wb_busy, ram_we}); end
      set_op(8'h81, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      wb_req = 1'b1;
      tick;
      wb_req = 1'b0;
      tick;
      n_checks++; if ({wb_done, w_reg, status_z} !== {1'b1, 8'h81, 1'b0}) begin n_errors++; $display("FAIL mid_after: got %b/%h/%b want 1/81/0", wb_done, w_reg, status_z); end
      tick;
   endtask

   initial begin
      test_reset;
      test_w_path;
      test_ram_path;
      test_status;
      test_timeout;
      test_back_to_back;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
